// File: rtl/tim1_cnt_core.sv
// tim1_cnt_core: TIM1 time-base and capture/compare-1 engine.
//
// Runs a prescaled up/down counter against an auto-reload value (ARR) and the
// channel-1 compare value (CCR1). Produces registered one-cycle load strobes for
// the UIF and CC1IF status flags, plus the registered channel-1 PWM output.
//
// Ports:
//   clk          timer kernel clock
//   rst_isr      asynchronous active-high reset
//   cen          counter enable (level)
//   dir          0 = up-count, 1 = down-count
//   opm          one-pulse mode: stop counting on the update event
//   arpe         ARR preload enable
//   ug           software update generation (one-cycle pulse)
//   wr_psc       write strobe, prescaler preload
//   wr_arr       write strobe, auto-reload preload
//   wr_ccr1      write strobe, compare value
//   wr_cnt       write strobe, counter (no update event)
//   wdata        bus write data
//   cnt          current counter value
//   run          counter active
//   ld_sr_uif    update-event strobe to UIF
//   ld_sr_cc1if  compare-match strobe to CC1IF
//   i_uif        UIF flag data (constant 1)
//   i_cc1if      CC1IF flag data (constant 1)
//   oc1          channel-1 PWM output

module tim1_cnt_core #(
    parameter int unsigned    W       = 16,
    parameter logic [W-1:0]   RST_ARR = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst_isr,
    input  logic         cen,
    input  logic         dir,
    input  logic         opm,
    input  logic         arpe,
    input  logic         ug,
    input  logic         wr_psc,
    input  logic         wr_arr,
    input  logic         wr_ccr1,
    input  logic         wr_cnt,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] cnt,
    output logic         run,
    output logic         ld_sr_uif,
    output logic         ld_sr_cc1if,
    output logic         i_uif,
    output logic         i_cc1if,
    output logic         oc1
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StOpmStop
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] psc_pre_q, psc_pre_d;
    logic [W-1:0] psc_sh_q, psc_sh_d;
    logic [W-1:0] arr_pre_q, arr_pre_d;
    logic [W-1:0] arr_sh_q, arr_sh_d;
    logic [W-1:0] ccr1_q, ccr1_d;
    logic [W-1:0] psc_cnt_q, psc_cnt_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         uif_q, uif_d;
    logic         cc1if_q, cc1if_d;
    logic         oc1_q, oc1_d;

    logic         tick;
    logic         uev;

    always_comb begin
        tick      = (state_q == StRun) && (psc_cnt_q == psc_sh_q);

        // Prescaler only advances while running; ug restarts it from any state.
        psc_cnt_d = psc_cnt_q;
        if (state_q == StRun) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
        end
        if (ug) begin
            psc_cnt_d = '0;
        end

        // Counter next value, priority ug > wr_cnt > tick.
        cnt_d = cnt_q;
        uev   = 1'b0;
        if (ug) begin
            uev   = 1'b1;
            cnt_d = dir ? arr_sh_q : '0;
        end else if (wr_cnt) begin
            cnt_d = wdata;
        end else if (tick) begin
            if (!dir) begin
                if (cnt_q == arr_sh_q) begin
                    cnt_d = '0;
                    uev   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = arr_sh_q;
                    uev   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // Shadows take the preload's next value so a write coinciding with an
        // update event is captured immediately.
        psc_pre_d = wr_psc ? wdata : psc_pre_q;
        psc_sh_d  = uev ? psc_pre_d : psc_sh_q;
        arr_pre_d = wr_arr ? wdata : arr_pre_q;
        arr_sh_d  = (uev || (wr_arr && !arpe)) ? arr_pre_d : arr_sh_q;
        ccr1_d    = wr_ccr1 ? wdata : ccr1_q;

        uif_d     = uev;
        cc1if_d   = (cnt_d != cnt_q) && (cnt_d == ccr1_q);
        oc1_d     = dir ? (cnt_d <= ccr1_q) : (cnt_d < ccr1_q);

        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cen) state_d = StRun;
            StRun:     if (uev && opm) state_d = StOpmStop;
            StOpmStop: state_d = StOpmStop;
            default:   state_d = StIdle;
        endcase
        if (!cen) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst_isr) begin
        if (rst_isr) begin
            state_q   <= StIdle;
            psc_pre_q <= '0;
            psc_sh_q  <= '0;
            arr_pre_q <= RST_ARR;
            arr_sh_q  <= RST_ARR;
            ccr1_q    <= '0;
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            uif_q     <= 1'b0;
            cc1if_q   <= 1'b0;
            oc1_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_pre_q <= psc_pre_d;
            psc_sh_q  <= psc_sh_d;
            arr_pre_q <= arr_pre_d;
            arr_sh_q  <= arr_sh_d;
            ccr1_q    <= ccr1_d;
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
            uif_q     <= uif_d;
            cc1if_q   <= cc1if_d;
            oc1_q     <= oc1_d;
        end
    end

    assign cnt         = cnt_q;
    assign run         = (state_q == StRun);
    assign ld_sr_uif   = uif_q;
    assign ld_sr_cc1if = cc1if_q;
    assign oc1         = oc1_q;
    assign i_uif       = 1'b1;
    assign i_cc1if     = 1'b1;

endmodule

// File: tb/tb_tim1_cnt_core.sv
// tb_tim1_cnt_core: directed self-checking bench for tim1_cnt_core.
// Expected per-cycle outputs are queued when a step is driven and popped and
// compared after the following clock edge.

module tb_tim1_cnt_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_isr;
    logic         cen, dir, opm, arpe, ug;
    logic         wr_psc, wr_arr, wr_ccr1, wr_cnt;
    logic [W-1:0] wdata;
    logic [W-1:0] cnt;
    logic         run, ld_sr_uif, ld_sr_cc1if, i_uif, i_cc1if, oc1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] c;
        logic         u;
        logic         cc;
        logic         o;
        logic         r;
    } exp_t;

    exp_t sb[$];

    tim1_cnt_core #(
        .W       (16),
        .RST_ARR (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst_isr     (rst_isr),
        .cen         (cen),
        .dir         (dir),
        .opm         (opm),
        .arpe        (arpe),
        .ug          (ug),
        .wr_psc      (wr_psc),
        .wr_arr      (wr_arr),
        .wr_ccr1     (wr_ccr1),
        .wr_cnt      (wr_cnt),
        .wdata       (wdata),
        .cnt         (cnt),
        .run         (run),
        .ld_sr_uif   (ld_sr_uif),
        .ld_sr_cc1if (ld_sr_cc1if),
        .i_uif       (i_uif),
        .i_cc1if     (i_cc1if),
        .oc1         (oc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cnt"},   cnt,         16'd0);
        chk({tag, ".run"},   16'(run),         16'd0);
        chk({tag, ".uif"},   16'(ld_sr_uif),   16'd0);
        chk({tag, ".cc1if"}, 16'(ld_sr_cc1if), 16'd0);
        chk({tag, ".oc1"},   16'(oc1),         16'd0);
        chk({tag, ".i_uif"}, 16'(i_uif),       16'd1);
        chk({tag, ".i_cc1"}, 16'(i_cc1if),     16'd1);
    endtask

    // Queue the expectation for the coming edge, clock, then pop and compare.
    task automatic step(input string tag, input logic [W-1:0] c, input logic u,
                        input logic cc, input logic o, input logic r);
        exp_t e;
        e.tag = tag; e.c = c; e.u = u; e.cc = cc; e.o = o; e.r = r;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.tag, ".cnt"},   cnt,              e.c);
        chk({e.tag, ".uif"},   16'(ld_sr_uif),   16'(e.u));
        chk({e.tag, ".cc1if"}, 16'(ld_sr_cc1if), 16'(e.cc));
        chk({e.tag, ".oc1"},   16'(oc1),         16'(e.o));
        chk({e.tag, ".run"},   16'(run),         16'(e.r));
    endtask

    task automatic clear_inputs();
        cen = 0; dir = 0; opm = 0; arpe = 0; ug = 0;
        wr_psc = 0; wr_arr = 0; wr_ccr1 = 0; wr_cnt = 0; wdata = '0;
    endtask

    task automatic do_reset();
        rst_isr = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst_isr = 1'b0;
        @(posedge clk); #1;
    endtask

    // sel: 0 psc, 1 arr, 2 ccr1, 3 cnt, 4 ug
    task automatic bus_wr(input int sel, input logic [W-1:0] d);
        wdata = d;
        case (sel)
            0: wr_psc  = 1'b1;
            1: wr_arr  = 1'b1;
            2: wr_ccr1 = 1'b1;
            3: wr_cnt  = 1'b1;
            default: ug = 1'b1;
        endcase
        @(posedge clk); #1;
        wr_psc = 0; wr_arr = 0; wr_ccr1 = 0; wr_cnt = 0; ug = 0;
    endtask

    initial begin
        logic [W-1:0] c;
        logic         first;

        rst_isr = 1'b1;
        clear_inputs();
        #3;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_isr = 1'b0;
        @(posedge clk); #1;

        // Test 1: psc=0, arr=4, up-count.
        bus_wr(1, 16'd4);
        cen = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step($sformatf("t1.%0d", i), 16'(i % 5), (i > 0) && (i % 5 == 0),
                 (i > 0) && (i % 5 == 0), 1'b0, 1'b1);
        end
        cen = 1'b0;
        step("t1.stop", 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1.frz", 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 2: psc=2, arr=3, ccr1=2, up-count.
        do_reset();
        bus_wr(0, 16'd2);
        bus_wr(1, 16'd3);
        bus_wr(2, 16'd2);
        bus_wr(4, 16'd0);
        @(posedge clk); #1;
        cen = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            if (i < 3) begin
                c = 16'd0;
                first = 1'b0;
            end else begin
                c = 16'(((i - 3) / 3 + 1) % 4);
                first = ((i - 3) % 3 == 0);
            end
            step($sformatf("t2.%0d", i), c, first && (c == 0), first && (c == 2),
                 (c < 2), 1'b1);
        end

        // Test 3a: arpe=1, ARR rewritten mid-period takes effect after one wrap.
        do_reset();
        arpe = 1'b1;
        bus_wr(1, 16'd9);
        bus_wr(4, 16'd0);
        cen = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            if (i == 6) begin
                wdata = 16'd3;
                wr_arr = 1'b1;
            end
            c = (i <= 9) ? 16'(i) : 16'((i - 10) % 4);
            step($sformatf("t3a.%0d", i), c, (i == 10) || (i == 14),
                 (i == 10) || (i == 14), 1'b0, 1'b1);
            wr_arr = 1'b0;
        end

        // Test 3b: arpe=0, ARR drops below cnt, counter runs through 0xFFFF.
        do_reset();
        bus_wr(1, 16'd9);
        cen = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i == 6) begin
                wdata = 16'd3;
                wr_arr = 1'b1;
            end
            step($sformatf("t3b.%0d", i), 16'(i), 1'b0, 1'b0, 1'b0, 1'b1);
            wr_arr = 1'b0;
        end
        wdata = 16'hFFFE;
        wr_cnt = 1'b1;
        step("t3b.ld", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        wr_cnt = 1'b0;
        step("t3b.max", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3b.ovf", 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("t3b.c1", 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3b.c2", 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3b.c3", 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3b.wrap", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Test 4: down-count, arr=3, one-pulse mode.
        do_reset();
        dir = 1'b1;
        opm = 1'b1;
        bus_wr(1, 16'd3);
        ug = 1'b1;
        step("t4.ug", 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        ug = 1'b0;
        cen = 1'b1;
        step("t4.e0", 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t4.e1", 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t4.e2", 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t4.e3", 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("t4.e4", 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4.e5", 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4.e6", 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cen = 1'b0;
        step("t4.off", 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cen = 1'b1;
        step("t4.re0", 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t4.re1", 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Test 5: ug and wr_cnt together, psc=5 loaded by the ug.
        do_reset();
        bus_wr(0, 16'd5);
        cen = 1'b1;
        step("t5.e0", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t5.e1", 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t5.e2", 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        ug = 1'b1;
        wr_cnt = 1'b1;
        wdata = 16'd7;
        step("t5.ug", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        ug = 1'b0;
        wr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("t5.h%0d", i), 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step("t5.tick", 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Test 6: asynchronous reset while ld_sr_uif is high.
        do_reset();
        bus_wr(1, 16'd4);
        cen = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            step($sformatf("t6.%0d", i), 16'(i % 5), (i == 5), (i == 5), 1'b0, 1'b1);
        end
        #2;
        rst_isr = 1'b1;
        #1;
        chk_reset_vals("t6.arst");
        clear_inputs();
        @(negedge clk);
        rst_isr = 1'b0;
        step("t6.post", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tim1_cnt_core.md
# tim1_cnt_core

Time-base and capture/compare-1 engine for TIM1. It runs a prescaled 16-bit up/down counter against an auto-reload value and a channel-1 compare value. It produces the one-cycle, glitch-free registered load strobes that set the TIM1 status flags UIF and CC1IF. It also drives the channel-1 PWM output and exposes the live count to the bus register file.

## Interface
Parameters:
- W, 16, counter/prescaler/ARR/CCR1 width
- RST_ARR, 16'hFFFF, reset value of ARR (preload and shadow)

Ports:
- clk  in  1  timer kernel clock
- rst_isr  in  1  reset, asynchronous, active-high
- cen  in  1  counter enable (level, from CR1)
- dir  in  1  0 = up-count, 1 = down-count
- opm  in  1  one-pulse mode
- arpe  in  1  ARR preload enable
- ug  in  1  software update generation, one-cycle pulse
- wr_psc, wr_arr, wr_ccr1, wr_cnt  in  1 each  bus write strobes, one cycle
- wdata  in  W  bus write data
- cnt  out  W  current counter value
- run  out  1  counter active (cen AND NOT opm-stopped)
- ld_sr_uif  out  1  update-event strobe to the UIF flag
- ld_sr_cc1if  out  1  compare-match strobe to the CC1IF flag
- i_uif, i_cc1if  out  1 each  flag data, constant 1
- oc1  out  1  channel-1 PWM output, registered

## Operation
- Registers: psc_pre/psc_sh, arr_pre/arr_sh, ccr1, psc_cnt, cnt. PSC and CCR1 writes go to the preload register. The PSC shadow loads only on an update event. ARR writes go to arr_pre. If arpe=0, arr_sh also loads on the same edge; if arpe=1, arr_sh loads only on an update event.
- State machine with three states:
  - IDLE: run=0, counter frozen. Entered from reset, from any state when cen=0, and from RUN via OPM_STOP.
  - RUN: run=1, counting. Entered from IDLE when cen=1.
  - OPM_STOP: run=0, counter frozen. Entered from RUN when an update event occurs with opm=1. The state returns to IDLE once cen is deasserted; software must deassert and reassert cen to restart.
- Prescaler: in RUN, psc_cnt increments every clk cycle. When psc_cnt == psc_sh, psc_cnt clears to 0 and a tick is generated. psc_sh=0 gives a tick every cycle.
- Counting on a tick:
  - Up-count: if cnt == arr_sh, cnt becomes 0 and an update event occurs; otherwise cnt+1.
  - Down-count: if cnt == 0, cnt becomes arr_sh and an update event occurs; otherwise cnt-1.
- Update event actions: load shadows, then pulse ld_sr_uif.
- ug: on the next edge, psc_cnt goes to 0 and cnt goes to 0 (up) or arr_sh (down). The update event actions apply, in any state.
- Compare: ld_sr_cc1if pulses whenever the next cnt value differs from the current cnt and equals ccr1, whether from a tick, ug or wr_cnt.
- oc1 (registered): up-count oc1 = (next cnt < ccr1); down-count oc1 = (next cnt <= ccr1). ccr1 > arr_sh gives constant 1. ccr1 = 0 in up-count gives constant 0.
- wr_cnt: loads cnt directly and does not generate an update event.
- Priority on the same edge: ug > wr_cnt > tick.
- Bus writes on the same edge as an update event: the new PSC/ARR value is taken into the shadow register.
- i_uif and i_cc1if are tied to 1, so the flag data input is stable before every strobe edge.

## Timing
- Reset values: cnt=0, psc_cnt=0, psc_pre=psc_sh=0, arr_pre=arr_sh=RST_ARR, ccr1=0, state IDLE, run=0, ld_sr_uif=0, ld_sr_cc1if=0, oc1=0.
- Both strobes are flop outputs, exactly one clk wide, asserted in the cycle after the edge that updated cnt. No combinational path from inputs to strobes, because the downstream flags are clocked on the strobe edge.
- Back-to-back events: with psc_sh=0 and arr_sh=0, ld_sr_uif stays high continuously. This is accepted; the flag holds 1.
- Startup latency: from cen=1 to the first cnt change is 2 + psc_sh cycles.
- Reset mid-count: all state clears immediately and the strobes drop asynchronously.

## Test plan
- Reset, then psc=0, arr=4, up-count, cen=1: cnt sequence 0,1,2,3,4,0. One ld_sr_uif pulse per 5 cycles, first pulse the cycle after the 4→0 edge.
- psc=2, arr=3, ccr1=2, up-count: cnt advances every 3 cycles. ld_sr_cc1if pulses once per period after 1→2. oc1 is high for cnt 0–1 and low for cnt 2–3.
- arpe=1, arr=9 running, write arr=3 mid-period: counter still wraps at 9 once, then at 3. With arpe=0 and cnt=5, writing arr=3 makes cnt run 6…65535 to wrap.
- Down-count, arr=3, opm=1: cnt 0→3 (uif), 2,1,0→3 (uif), then run=0 and cnt freezes at 3 in OPM_STOP.
- ug and wr_cnt=7 in the same cycle with psc=5: cnt goes to 0, psc_cnt goes to 0, and exactly one ld_sr_uif pulse occurs.
- Assert rst_isr mid-period with ld_sr_uif high: ld_sr_uif drops immediately and all outputs match their reset values before the next clk edge.
